// File: rtl/rev_pkg.sv
// Shared types for the reversible integer square-root unit.
package rev_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int W_DEF      = 8;
  localparam int ITER_W_DEF = $clog2(W_DEF);

  // Iteration counter width for a given root width; never narrower than 1 bit.
  function automatic int iter_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/rev_full_subtractor.sv
// Reversible full subtractor built from CNOT / Toffoli primitives.
module rev_cnot (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module rev_toffoli (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);
  assign y = c ^ (a & b);
endmodule

// a - b - bin: run a reversible full adder on ~a, whose carry is the borrow
// and whose sum is the complemented difference.
module rev_full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout,
  output logic g0,
  output logic g1
);
  logic na, t0, p, s;

  assign na = ~a;

  rev_toffoli u_t0 (.a(na), .b(b),   .c(1'b0), .y(t0));
  rev_cnot    u_c0 (.a(na), .b(b),   .y(p));
  rev_toffoli u_t1 (.a(p),  .b(bin), .c(t0),   .y(bout));
  rev_cnot    u_c1 (.a(p),  .b(bin), .y(s));

  assign diff = ~s;
  assign g0   = p;
  assign g1   = ~na;
endmodule

// File: rtl/rev_isqrt_seq.sv
// Sequential restoring integer square root, one root bit per clock.
module rev_isqrt_seq
  import rev_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] radicand,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   root,
  output logic [W:0]     rem
);
  localparam int ITER_W = iter_w(W);
  localparam int CW     = W + 2;

  state_t state, state_nx;

  logic [2*W-1:0]    n_sh;
  logic [CW-1:0]     rem_r, cur, trial, diff;
  logic [W-1:0]      root_r;
  logic [ITER_W-1:0] iter;
  logic [CW:0]       bchain;
  logic              bout, accept;

  // Partial remainder never exceeds 2*root, so its top two bits fall off here.
  assign cur       = {rem_r[W-1:0], n_sh[2*W-1 -: 2]};
  assign trial     = {root_r, 2'b01};
  assign bchain[0] = 1'b0;
  assign bout      = bchain[CW];

  generate
    for (genvar g = 0; g < CW; g++) begin : g_sub
      rev_full_subtractor u_fs (
        .a    (cur[g]),
        .b    (trial[g]),
        .bin  (bchain[g]),
        .diff (diff[g]),
        .bout (bchain[g+1]),
        .g0   (),
        .g1   ()
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = CALC;
      end
      CALC: begin
        if (iter == '0) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      n_sh   <= '0;
      rem_r  <= '0;
      root_r <= '0;
      iter   <= '0;
    end else if (accept) begin
      n_sh   <= radicand;
      rem_r  <= '0;
      root_r <= '0;
      iter   <= ITER_W'(W - 1);
    end else if (state == CALC) begin
      rem_r  <= bout ? cur : diff;
      root_r <= {root_r[W-2:0], ~bout};
      n_sh   <= {n_sh[2*W-3:0], 2'b00};
      if (iter != '0) iter <= iter - 1'b1;
    end
  end

  assign root = root_r;
  assign rem  = rem_r[W:0];

  a_rem_top_zero : assert property (@(posedge clk) disable iff (rst)
    (state == DONE) |-> (rem_r[W+1] == 1'b0));

endmodule

// File: tb/tb_rev_isqrt_seq.sv
// Directed-vector bench for rev_isqrt_seq at W=8 plus an exhaustive W=4 sweep.
module tb_rev_isqrt_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv8, ir8, ov8, or8;
  logic [15:0] rad8;
  logic [7:0]  root8;
  logic [8:0]  rem8;
  logic        iv4, ir4, ov4, or4;
  logic [7:0]  rad4;
  logic [3:0]  root4;
  logic [4:0]  rem4;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rev_isqrt_seq #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .radicand(rad8),
    .out_valid(ov8), .out_ready(or8), .root(root8), .rem(rem8)
  );

  rev_isqrt_seq #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .radicand(rad4),
    .out_valid(ov4), .out_ready(or4), .root(root4), .rem(rem4)
  );

  typedef struct {
    logic [15:0] rad;
    logic [7:0]  root;
    logic [8:0]  rem;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int isqrt(input int r);
    int s;
    s = 0;
    while ((s + 1) * (s + 1) <= r) s++;
    return s;
  endfunction

  // Returns at #1 after the accept edge; scrambles radicand afterwards.
  task automatic offer8(input logic [15:0] r);
    int n;
    n = 0;
    while (!ir8 && n < 50) begin tick(); n++; end
    chk("offer8_ready", {31'd0, ir8}, 32'd1);
    iv8  = 1'b1;
    rad8 = r;
    tick();
    iv8  = 1'b0;
    rad8 = 16'hA5A5;
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    while (!ov8 && lat < 50) begin tick(); lat++; end
  endtask

  task automatic consume8();
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    chk("consume_in_ready", {31'd0, ir8}, 32'd1);
    chk("consume_out_valid", {31'd0, ov8}, 32'd0);
  endtask

  initial begin
    int  lat;
    bit  seen;

    vecs[0]  = '{16'd144,   8'd12,  9'd0};
    vecs[1]  = '{16'd65535, 8'd255, 9'd510};
    vecs[2]  = '{16'd0,     8'd0,   9'd0};
    vecs[3]  = '{16'd145,   8'd12,  9'd1};
    vecs[4]  = '{16'd1000,  8'd31,  9'd39};
    vecs[5]  = '{16'd50,    8'd7,   9'd1};
    vecs[6]  = '{16'd1,     8'd1,   9'd0};
    vecs[7]  = '{16'd2,     8'd1,   9'd1};
    vecs[8]  = '{16'd3,     8'd1,   9'd2};
    vecs[9]  = '{16'd255,   8'd15,  9'd30};
    vecs[10] = '{16'd256,   8'd16,  9'd0};
    vecs[11] = '{16'd65025, 8'd255, 9'd0};
    vecs[12] = '{16'd65024, 8'd254, 9'd508};
    vecs[13] = '{16'd4,     8'd2,   9'd0};

    rst = 1'b1; iv8 = 1'b0; or8 = 1'b0; rad8 = '0;
    iv4 = 1'b0; or4 = 1'b1; rad4 = '0;
    tick(); tick(); tick();
    chk("rst_in_ready",  {31'd0, ir8}, 32'd1);
    chk("rst_out_valid", {31'd0, ov8}, 32'd0);
    chk("rst_root",      {24'd0, root8}, 32'd0);
    chk("rst_rem",       {23'd0, rem8}, 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      offer8(vecs[i].rad);
      wait_done8(lat);
      chk("vec_latency", lat, 32'd8);
      chk("vec_root", {24'd0, root8}, {24'd0, vecs[i].root});
      chk("vec_rem",  {23'd0, rem8},  {23'd0, vecs[i].rem});
      consume8();
    end

    // Result held stable while the consumer stalls.
    offer8(16'd145);
    wait_done8(lat);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", {31'd0, ov8}, 32'd1);
      chk("hold_root", {24'd0, root8}, 32'd12);
      chk("hold_rem",  {23'd0, rem8}, 32'd1);
      tick();
    end
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
    chk("hold_idle_after", {31'd0, ir8}, 32'd1);

    // Reset landing on the 4th CALC edge.
    offer8(16'd1000);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready",  {31'd0, ir8}, 32'd1);
    chk("midrst_out_valid", {31'd0, ov8}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (ov8) seen = 1'b1;
      tick();
    end
    chk("midrst_no_valid", {31'd0, seen}, 32'd0);
    offer8(16'd1000);
    wait_done8(lat);
    chk("after_rst_root", {24'd0, root8}, 32'd31);
    chk("after_rst_rem",  {23'd0, rem8}, 32'd39);
    consume8();

    // Offer during CALC is dropped.
    offer8(16'd50);
    tick();
    chk("calc_in_ready", {31'd0, ir8}, 32'd0);
    iv8  = 1'b1;
    rad8 = 16'd9;
    tick();
    iv8  = 1'b0;
    wait_done8(lat);
    chk("ign_root", {24'd0, root8}, 32'd7);
    chk("ign_rem",  {23'd0, rem8}, 32'd1);
    consume8();
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (ov8 || !ir8) seen = 1'b1;
      tick();
    end
    chk("ign_not_processed", {31'd0, seen}, 32'd0);

    // W=4 exhaustive, in_valid and out_ready held high.
    fork
      begin : feeder
        int n;
        iv4 = 1'b1;
        for (int i = 0; i < 256; i++) begin
          n = 0;
          while (!ir4 && n < 20) begin tick(); n++; end
          if (n >= 20) chk("feed_ready", {31'd0, ir4}, 32'd1);
          rad4 = 8'(i);
          tick();
        end
        iv4 = 1'b0;
      end
      begin : collector
        int got, last, t, r, ex;
        got = 0; last = -1; t = 0;
        while (got < 256 && t < 3000) begin
          tick();
          t++;
          if (ov4) begin
            ex = isqrt(got);
            chk("x4_root", {28'd0, root4}, ex);
            chk("x4_rem",  {27'd0, rem4}, got - ex * ex);
            r = int'(root4) * int'(root4) + int'(rem4);
            chk("x4_identity", r, got);
            chk("x4_rem_bound", {31'd0, (int'(rem4) <= 2 * int'(root4))}, 32'd1);
            if (last >= 0) chk("x4_spacing", cyc - last, 32'd6);
            last = cyc;
            got++;
          end
        end
        chk("x4_count", got, 32'd256);
      end
    join

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rev_isqrt_seq.md
# rev_isqrt_seq

Sequential integer square-root unit, the inverse datapath to the reversible squarer. It accepts a 2W-bit radicand and returns the W-bit root and the (W+1)-bit remainder, so that radicand = root² + rem. It computes one root bit per clock using a restoring digit-by-digit algorithm. The trial subtraction is a ripple chain of reversible full subtractors, the borrow-side counterpart of the reversible full adder used in the squarer. It sits after the squarer in the self-check path and is also usable standalone behind a valid/ready handshake.

## Interface
- W, default 8: root width; radicand is 2W bits; legal W ≥ 2.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  radicand offered.
- in_ready  out  1  block can accept; high only in IDLE.
- radicand  in  2W  unsigned operand, sampled on accept.
- out_valid  out  1  result available; high only in DONE.
- out_ready  in  1  consumer takes result.
- root  out  W  floor(sqrt(radicand)).
- rem  out  W+1  radicand − root².

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch radicand into shift register N, clear rem_r (W+2 bits) and root_r, set iter=W−1, go to CALC.
- CALC, one iteration per cycle:
  - cur = (rem_r<<2) | N[2W−1:2W−2].
  - trial = (root_r<<2) | 1, computed at W+2 bits.
  - diff, bout = cur − trial through the subtractor chain; bout is the final borrow.
  - If bout=0: rem_r=diff, root_r=(root_r<<1)|1.
  - Else: rem_r=cur, root_r=root_r<<1.
  - N shifts left by 2.
  - When iter=0, go to DONE; otherwise iter decrements.
- DONE:
  - out_valid=1; root and rem are driven from registers and stay stable while out_valid&!out_ready.
  - On out_ready, go to IDLE.
- Width rules:
  - All intermediates are unsigned, W+2 bits, and never overflow.
  - rem output = rem_r[W:0]; rem_r[W+1] is always 0 in DONE.
- Outputs are registered; root and rem hold their last values in IDLE.
- in_valid while not in IDLE is ignored (in_ready=0); radicand changes during CALC have no effect.
- Reversible chain: W+2 subtractor cells, with borrow-in of the LSB cell tied to 0. Garbage outputs are left unconnected at this level.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, root=0, rem=0, iter=0.
- rst during CALC or DONE returns to IDLE on that edge. The in-flight result is discarded and no out_valid pulse appears.
- Latency:
  - Accept edge at cycle k.
  - CALC occupies edges k+1…k+W.
  - out_valid is high after edge k+W.
- Throughput: one result per W+2 cycles when in_valid and out_ready are held high. This counts the DONE cycle with out_ready=1 returning to IDLE, plus the IDLE cycle.
- out_valid&out_ready on the same edge as a new in_valid:
  - The new operand is not accepted on that edge, because in_ready=0 in DONE.
  - It is accepted on the following IDLE edge.
- The subtractor chain is combinational within one cycle; the critical path is the W+2-cell borrow ripple.

## Structure
- Package rev_pkg:
  - state enum (IDLE, CALC, DONE).
  - localparam for the iteration counter width, $clog2(W).
- Sub-module rev_full_subtractor:
  - Ports A, B, Bin -> Diff, Bout, plus two garbage outputs.
  - Built from the existing reversible gate primitives.
  - Instantiated W+2 times in a generate loop inside rev_isqrt_seq.

## Test plan
- W=8, radicand=144 -> after 8 CALC edges, out_valid=1, root=12, rem=0.
- W=8, radicand=65535 -> root=255, rem=510; radicand=0 -> root=0, rem=0.
- W=8, radicand=145, out_ready held low 5 cycles -> root=13? no: root=12, rem=1, stable for all 5 cycles, IDLE one edge after out_ready rises.
- Assert rst on the 4th CALC cycle of radicand=1000 -> next cycle IDLE, out_valid never asserts. A following radicand=1000 gives root=31, rem=39.
- in_valid pulsed with radicand=9 during CALC of radicand=50 -> ignored. Result is root=7, rem=1; 9 is not later processed unless re-offered.
- W=4 exhaustive, all 256 radicands back-to-back -> root²+rem=radicand and rem≤2·root for every result; result spacing is exactly 6 cycles.
